image_mem_arbiter: RTL

//  Sequences and shares the single-port sprite image memory (1-cycle registered read,
//  one address port) between a display-side sprite fetch reader and a host-side sprite

---
 rtl/image_mem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/image_mem_arbiter.sv
// Arbiter for the single-port sprite image memory: shares it between the display read port
// and the host write port, and runs a full-memory clear sweep on command.
module image_mem_arbiter #(
    parameter int unsigned         ADDR_W    = 4,
    parameter int unsigned         DATA_W    = 8,
    parameter int unsigned         MAX_WAIT  = 4,
    parameter logic [DATA_W-1:0]   CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              rd_valid_q;
    logic              clr_done_q, clr_done_d;

    logic              rd_gnt_c, wr_ready_c, we_c;
    logic [ADDR_W-1:0] a_c;
    logic [DATA_W-1:0] din_c;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        rd_gnt_c   = 1'b0;
        wr_ready_c = 1'b0;
        we_c       = 1'b0;
        a_c        = '0;
        din_c      = '0;
        unique case (state_q)
            StIdle: begin
                // Reads win ties until the pending write has been denied MAX_WAIT times.
                if (rd_req && !(wr_valid && (wait_q == WAIT_MAX))) begin
                    rd_gnt_c = 1'b1;
                    a_c      = rd_addr;
                end else if (wr_valid) begin
                    wr_ready_c = 1'b1;
                    we_c       = 1'b1;
                    a_c        = wr_addr;
                    din_c      = wr_data;
                end
                if (!wr_valid || wr_ready_c) begin
                    wait_d = '0;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
                if (clr_start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                we_c      = 1'b1;
                a_c       = clr_cnt_q;
                din_c     = CLEAR_VAL;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d    = StIdle;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_gnt_c;
            clr_done_q <= clr_done_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign rd_gnt   = rd_gnt_c & rst_n;
    assign wr_ready = wr_ready_c & rst_n;
    assign mem_we   = we_c & rst_n;
    assign mem_a    = rst_n ? a_c : '0;
    assign mem_din  = rst_n ? din_c : '0;
    assign rd_valid = rd_valid_q;
    assign rd_data  = mem_dout;
    assign clr_busy = (state_q == StClear);
    assign clr_done = clr_done_q;

endmodule
